// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ALU front end. Decodes RV64I fields into a 3-bit ALU opcode,
//            sign-extends immediates, selects operand 2 and issues the
//            bundle through a valid/ready port backed by a 2-entry skid
//            buffer (main register M, skid register S).
// Options  : ALU_ILLEGAL_DROP_EN - drop illegal bundles and count them in a
//            saturating counter instead of forwarding them.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN          = 64,
    parameter int ILLEGAL_CNT_W = 8
) (
    input  logic                     clk_in,
    input  logic                     resetN_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [31:0]              instr_in,
    input  logic [XLEN-1:0]          rs1Data_in,
    input  logic [XLEN-1:0]          rs2Data_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [XLEN-1:0]          operand1_out,
    output logic [XLEN-1:0]          operand2_out,
    output logic [2:0]               aluOpcode_out,
    output logic                     isBranch_out,
    output logic                     branchNe_out,
    output logic                     illegal_out,
    output logic [ILLEGAL_CNT_W-1:0] illegalCount_out
);

    localparam logic [2:0] c_OP_SUB = 3'b000;
    localparam logic [2:0] c_OP_AND = 3'b001;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_ADD = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [2:0]      opc;
        logic            is_branch;
        logic            branch_ne;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    bundle_t         w_dec;
    logic            w_accept;
    logic            w_push;
    logic            w_drain;
    logic            w_unused_bits;

    state_t          r_state;
    bundle_t         r_m;
    bundle_t         r_s;
    logic            r_valid;
    logic            r_ready;

    assign w_opcode = instr_in[6:0];
    assign w_funct3 = instr_in[14:12];
    assign w_funct7 = instr_in[31:25];
    assign w_imm_i  = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign w_imm_s  = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};

    // Register-index fields are resolved upstream; only the decode fields matter here.
    assign w_unused_bits = ^instr_in[19:15];

    // Combinational instruction decode; anything unsupported falls back to ADD rs1,rs2 flagged illegal.
    always_comb begin
        w_dec           = '0;
        w_dec.op1       = rs1Data_in;
        w_dec.op2       = rs2Data_in;
        w_dec.opc       = c_OP_ADD;
        w_dec.is_branch = 1'b0;
        w_dec.branch_ne = 1'b0;
        w_dec.illegal   = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
                    w_dec.opc = c_OP_ADD;
                end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
                    w_dec.opc = c_OP_SUB;
                end else if (w_funct3 == 3'b111 && w_funct7 == 7'b0000000) begin
                    w_dec.opc = c_OP_AND;
                end else if (w_funct3 == 3'b110 && w_funct7 == 7'b0000000) begin
                    w_dec.opc = c_OP_OR;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                case (w_funct3)
                    3'b000: begin w_dec.opc = c_OP_ADD; w_dec.op2 = w_imm_i; end
                    3'b111: begin w_dec.opc = c_OP_AND; w_dec.op2 = w_imm_i; end
                    3'b110: begin w_dec.opc = c_OP_OR;  w_dec.op2 = w_imm_i; end
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: w_dec.op2 = w_imm_i;
            7'b0100011: w_dec.op2 = w_imm_s;
            7'b1100011: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    w_dec.opc       = c_OP_SUB;
                    w_dec.is_branch = 1'b1;
                    w_dec.branch_ne = w_funct3[0];
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    assign w_accept = valid_in & r_ready;
    assign w_drain  = r_valid & ready_in;

`ifdef ALU_ILLEGAL_DROP_EN
    logic [ILLEGAL_CNT_W-1:0] r_ill_cnt;

    assign w_push = w_accept & ~w_dec.illegal;

    // Count accepted-but-dropped illegal bundles, holding at all-ones.
    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            r_ill_cnt <= '0;
        end else if (w_accept && w_dec.illegal && (r_ill_cnt != {ILLEGAL_CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign illegalCount_out = r_ill_cnt;
    assign illegal_out      = 1'b0;
`else
    assign w_push           = w_accept;
    assign illegalCount_out = '0;
    assign illegal_out      = r_m.illegal;
`endif

    // Skid-buffer control: M feeds the ALU, S absorbs the one bundle accepted while M stalls.
    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            r_state <= S_EMPTY;
            r_m     <= '0;
            r_s     <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_m     <= w_dec;
                        r_valid <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_drain) begin
                        r_m <= w_dec;
                    end else if (w_push) begin
                        r_s     <= w_dec;
                        r_ready <= 1'b0;
                        r_state <= S_FULL;
                    end else if (w_drain) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        r_m     <= r_s;
                        r_ready <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out     = r_ready;
    assign valid_out     = r_valid;
    assign operand1_out  = r_m.op1;
    assign operand2_out  = r_m.op2;
    assign aluOpcode_out = r_m.opc;
    assign isBranch_out  = r_m.is_branch;
    assign branchNe_out  = r_m.branch_ne;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed self-checking bench for alu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int XLEN          = 64;
    localparam int ILLEGAL_CNT_W = 8;

    localparam logic [31:0] c_ADD  = 32'h002081B3;
    localparam logic [31:0] c_SUB  = 32'h402081B3;
    localparam logic [31:0] c_ORI  = 32'hFFF0E193;
    localparam logic [31:0] c_SD   = 32'hFE20BC23;
    localparam logic [31:0] c_AND  = 32'h0020F1B3;
    localparam logic [31:0] c_BNE  = 32'h00209463;
    localparam logic [31:0] c_BEQ  = 32'h00208063;
    localparam logic [31:0] c_MUL  = 32'h022081B3;

    logic                     clk_in;
    logic                     resetN_in;
    logic                     valid_in;
    logic                     ready_out;
    logic [31:0]              instr_in;
    logic [XLEN-1:0]          rs1Data_in;
    logic [XLEN-1:0]          rs2Data_in;
    logic                     valid_out;
    logic                     ready_in;
    logic [XLEN-1:0]          operand1_out;
    logic [XLEN-1:0]          operand2_out;
    logic [2:0]               aluOpcode_out;
    logic                     isBranch_out;
    logic                     branchNe_out;
    logic                     illegal_out;
    logic [ILLEGAL_CNT_W-1:0] illegalCount_out;

    int total;
    int bad;

    alu_issue_stage #(
        .XLEN          (XLEN),
        .ILLEGAL_CNT_W (ILLEGAL_CNT_W)
    ) dut (
        .clk_in           (clk_in),
        .resetN_in        (resetN_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .instr_in         (instr_in),
        .rs1Data_in       (rs1Data_in),
        .rs2Data_in       (rs2Data_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .operand1_out     (operand1_out),
        .operand2_out     (operand2_out),
        .aluOpcode_out    (aluOpcode_out),
        .isBranch_out     (isBranch_out),
        .branchNe_out     (branchNe_out),
        .illegal_out      (illegal_out),
        .illegalCount_out (illegalCount_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [63:0] a, input logic [63:0] b);
        valid_in   = v;
        instr_in   = ins;
        rs1Data_in = a;
        rs2Data_in = b;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetN_in = 1'b0;
        ready_in  = 1'b0;
        drive(1'b0, 32'h0, 64'd0, 64'd0);

        #12;
        check_eq("rst_valid", {63'd0, valid_out}, 64'd0);
        check_eq("rst_ready", {63'd0, ready_out}, 64'd1);
        check_eq("rst_op1",   operand1_out, 64'd0);
        check_eq("rst_op2",   operand2_out, 64'd0);
        check_eq("rst_opc",   {61'd0, aluOpcode_out}, 64'd0);
        check_eq("rst_cnt",   {56'd0, illegalCount_out}, 64'd0);
        #1;
        resetN_in = 1'b1;
        #1;

        // Basic ADD, one-cycle latency.
        ready_in = 1'b1;
        drive(1'b1, c_ADD, 64'd5, 64'd7);
        step();
        check_eq("add_valid", {63'd0, valid_out}, 64'd1);
        check_eq("add_opc",   {61'd0, aluOpcode_out}, 64'h7);
        check_eq("add_op1",   operand1_out, 64'd5);
        check_eq("add_op2",   operand2_out, 64'd7);
        check_eq("add_ill",   {63'd0, illegal_out}, 64'd0);

        // Back-to-back SUB, ORI -1, store -8.
        drive(1'b1, c_SUB, 64'd10, 64'd3);
        step();
        check_eq("sub_opc", {61'd0, aluOpcode_out}, 64'h0);
        check_eq("sub_op2", operand2_out, 64'd3);
        drive(1'b1, c_ORI, 64'd0, 64'd99);
        step();
        check_eq("ori_opc", {61'd0, aluOpcode_out}, 64'h3);
        check_eq("ori_op2", operand2_out, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, c_SD, 64'd4, 64'd99);
        step();
        check_eq("sd_opc",   {61'd0, aluOpcode_out}, 64'h7);
        check_eq("sd_op2",   operand2_out, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("sd_valid", {63'd0, valid_out}, 64'd1);
        drive(1'b0, 32'h0, 64'd0, 64'd0);
        step();
        check_eq("drain_empty", {63'd0, valid_out}, 64'd0);

        // Stall with three ANDs queued behind a blocked ALU.
        ready_in = 1'b0;
        drive(1'b1, c_AND, 64'd1, 64'd0);
        step();
        check_eq("stall1_valid", {63'd0, valid_out}, 64'd1);
        check_eq("stall1_op1",   operand1_out, 64'd1);
        check_eq("stall1_opc",   {61'd0, aluOpcode_out}, 64'h1);
        check_eq("stall1_ready", {63'd0, ready_out}, 64'd1);
        drive(1'b1, c_AND, 64'd2, 64'd0);
        step();
        check_eq("stall2_ready", {63'd0, ready_out}, 64'd0);
        check_eq("stall2_op1",   operand1_out, 64'd1);
        drive(1'b1, c_AND, 64'd3, 64'd0);
        step();
        check_eq("stall3_ready", {63'd0, ready_out}, 64'd0);
        check_eq("stall3_op1",   operand1_out, 64'd1);
        ready_in = 1'b1;
        step();
        check_eq("rel1_op1",   operand1_out, 64'd2);
        check_eq("rel1_ready", {63'd0, ready_out}, 64'd1);
        step();
        check_eq("rel2_op1",   operand1_out, 64'd3);
        check_eq("rel2_valid", {63'd0, valid_out}, 64'd1);
        drive(1'b0, 32'h0, 64'd0, 64'd0);
        step();
        check_eq("rel3_empty", {63'd0, valid_out}, 64'd0);

        // Branches.
        drive(1'b1, c_BNE, 64'd9, 64'd9);
        step();
        check_eq("bne_opc", {61'd0, aluOpcode_out}, 64'h0);
        check_eq("bne_br",  {63'd0, isBranch_out}, 64'd1);
        check_eq("bne_ne",  {63'd0, branchNe_out}, 64'd1);
        check_eq("bne_op2", operand2_out, 64'd9);
        drive(1'b1, c_BEQ, 64'd4, 64'd6);
        step();
        check_eq("beq_br",  {63'd0, isBranch_out}, 64'd1);
        check_eq("beq_ne",  {63'd0, branchNe_out}, 64'd0);
        check_eq("beq_op2", operand2_out, 64'd6);

        // Illegal MUL.
        drive(1'b1, c_MUL, 64'd2, 64'd3);
        step();
`ifdef ALU_ILLEGAL_DROP_EN
        check_eq("mul_valid", {63'd0, valid_out}, 64'd0);
        check_eq("mul_ill",   {63'd0, illegal_out}, 64'd0);
        check_eq("mul_cnt",   {56'd0, illegalCount_out}, 64'd1);
        for (int i = 0; i < 299; i++) step();
        check_eq("cnt_sat",   {56'd0, illegalCount_out}, 64'd255);
        check_eq("sat_valid", {63'd0, valid_out}, 64'd0);
`else
        check_eq("mul_valid", {63'd0, valid_out}, 64'd1);
        check_eq("mul_ill",   {63'd0, illegal_out}, 64'd1);
        check_eq("mul_opc",   {61'd0, aluOpcode_out}, 64'h7);
        check_eq("mul_br",    {63'd0, isBranch_out}, 64'd0);
        check_eq("mul_op2",   operand2_out, 64'd3);
        check_eq("mul_cnt",   {56'd0, illegalCount_out}, 64'd0);
`endif
        drive(1'b0, 32'h0, 64'd0, 64'd0);
        step();

        // Fill both entries, then reset asynchronously mid-stall.
        ready_in = 1'b0;
        drive(1'b1, c_ADD, 64'd11, 64'd1);
        step();
        drive(1'b1, c_ADD, 64'd12, 64'd1);
        step();
        check_eq("full_ready", {63'd0, ready_out}, 64'd0);
        drive(1'b0, 32'h0, 64'd0, 64'd0);
        #2;
        resetN_in = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, valid_out}, 64'd0);
        check_eq("arst_ready", {63'd0, ready_out}, 64'd1);
        check_eq("arst_op1",   operand1_out, 64'd0);
        step();
        #2;
        resetN_in = 1'b1;
        ready_in  = 1'b1;
        step();
        check_eq("post_empty", {63'd0, valid_out}, 64'd0);
        drive(1'b1, c_ADD, 64'd21, 64'd22);
        step();
        check_eq("post_valid", {63'd0, valid_out}, 64'd1);
        check_eq("post_op1",   operand1_out, 64'd21);
        drive(1'b0, 32'h0, 64'd0, 64'd0);
        step();
        check_eq("post_drain", {63'd0, valid_out}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Front end of the ALU. Decodes RV64I instruction fields into the 3-bit ALU opcode, sign-extends immediates and selects operand 2. Issues a registered operand/opcode bundle to the ALU through a valid/ready interface with a 2-entry skid buffer. Sits between register read and the ALU in the execute stage.

Parameters:
XLEN, 64, datapath width of operands and immediates
ILLEGAL_CNT_W, 8, width of the illegal-instruction counter (used only with the optional feature)

Ports:
clk_in  input  1  clock, rising edge
resetN_in  input  1  reset, asynchronous, active-low
valid_in  input  1  upstream bundle valid
ready_out  output  1  stage can accept a bundle
instr_in  input  32  raw instruction word
rs1Data_in  input  XLEN  register file read port 1
rs2Data_in  input  XLEN  register file read port 2
valid_out  output  1  issued bundle valid
ready_in  input  1  ALU side accepts the bundle
operand1_out  output  XLEN  ALU operand 1
operand2_out  output  XLEN  ALU operand 2 (rs2 or immediate)
aluOpcode_out  output  3  000 SUB, 001 AND, 011 OR, 111 ADD
isBranch_out  output  1  bundle is BEQ/BNE; the consumer uses the ALU zero flag
branchNe_out  output  1  1 = BNE, 0 = BEQ; meaningful only when isBranch_out=1
illegal_out  output  1  instruction not supported by this ALU
illegalCount_out  output  ILLEGAL_CNT_W  saturating illegal count (feature only)

Behaviour:
- Decode is combinational on instr_in. opcode = instr[6:0], funct3 = instr[14:12], f7b5 = instr[30].
- R-type 0110011: f3=000 gives ADD when f7b5=0 and SUB when f7b5=1; f3=111 gives AND; f3=110 gives OR. op2 = rs2.
- I-type 0010011: f3=000 ADD, 111 AND, 110 OR. op2 = sext(instr[31:20]).
- Load 0000011 (any f3): ADD, op2 = sext(instr[31:20]).
- Store 0100011 (any f3): ADD, op2 = sext({instr[31:25], instr[11:7]}).
- Branch 1100011: f3=000 (BEQ) and f3=001 (BNE) give SUB with op2 = rs2, isBranch=1, and branchNe = f3[0].
- Any other opcode or funct combination: illegal=1, aluOpcode=111, op2=rs2, isBranch=0.
- op1 is always rs1. Sign extension replicates instr[31] up to XLEN.
- Handshake: a transfer happens when valid and ready are both high on a rising edge. Once valid_out=1, the payload is held stable until ready_in=1.
- Storage: main register M plus skid register S.
  - ready_out is registered and equals !S.valid.
  - Latency: 1 cycle from an accepted input to valid_out.
- States: EMPTY (M and S invalid), ONE (M valid), FULL (M and S valid).
  - EMPTY with accept: go to ONE.
  - ONE with accept and no drain: go to FULL (new bundle into S).
  - ONE with accept and drain: stay ONE (M reloaded).
  - ONE with drain only: go to EMPTY.
  - FULL with drain: S moves to M, go to ONE. No accept is possible in FULL because ready_out=0.
- Ordering is strictly FIFO. Throughput is 1 bundle per cycle when ready_in stays high.
- Reset, asserted asynchronously at any time, including mid-stall:
  - valid_out=0, ready_out=1.
  - All payload outputs are 0 and illegalCount_out=0.
  - Any in-flight bundles are discarded.
- After deassertion, the first accept is possible on the first rising edge.

Optional Feature:
Macro ALU_ILLEGAL_DROP_EN.
- Defined:
  - Illegal bundles are accepted (ready_out is honoured) but never enter M or S, so valid_out does not pulse for them.
  - illegalCount_out increments by 1 per dropped bundle and saturates at all-ones.
  - illegal_out is tied to 0.
- Undefined:
  - Illegal bundles are forwarded as ADD with illegal_out=1.
  - illegalCount_out is tied to 0 and no counter is present.

Test Plan:
- After reset, ADD x (instr 0x002081B3), rs1=5, rs2=7, ready_in=1 -> next cycle valid_out=1, aluOpcode=111, op1=5, op2=7, illegal=0.
- SUB (0x402081B3), then ORI with imm -1 (0xFFF0E193), then store with imm -8 (0xFE20BC23) back-to-back -> opcodes 000, 011, 111 in order; op2 = rs2, 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FFF8.
- ready_in=0 for 3 cycles while valid_in=1 with 3 ANDs (rs1=1, 2, 3) -> ready_out drops after the 2nd accept; payload held stable. Release ready_in -> rs1 1, 2, 3 delivered in order, none lost or duplicated.
- BNE (0x00209463), rs1=rs2=9 -> aluOpcode=000, isBranch=1, branchNe=1, op2=9.
- Illegal MUL (0x022081B3) -> without macro: valid_out=1, illegal_out=1, aluOpcode=111. With ALU_ILLEGAL_DROP_EN: no valid_out; illegalCount_out 0→1; 300 illegals saturate at 255.
- Assert resetN_in low asynchronously while FULL -> valid_out=0 and ready_out=1 immediately, without waiting for a clock edge; no stale bundle after release.
